adder_serial_ctrl: RTL and testbench

ADDER_SERIAL_CTRL -- requirements
Module: adder_serial_ctrl

---
 rtl/adders_pkg.sv | 14 +
 rtl/adder_1.sv | 14 +
 rtl/adder_serial_ctrl.sv | 96 +++++++++
 tb/tb_adder_serial_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/adders_pkg.sv
// Shared types and constants for the serial adder slice.
// Holds the controller state encoding and operation codes.
package adders_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_1.sv
// Single-bit full adder slice.
// The only arithmetic on operand bits in the serial datapath.
module adder_1 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/adder_serial_ctrl.sv
// Bit-serial add/subtract unit, one bit per clock, LSB first.
// Valid/ready request side in IDLE, result side in DONE.
module adder_serial_ctrl
  import adders_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          c_out_q;
  logic          ovf_q;

  logic          s_d;
  logic          co_d;

  adder_1 u_slice (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (s_d),
    .c_o (co_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (sub == OP_SUB) ? ~b : b;
            carry_q <= (sub == OP_SUB);
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= {s_d, res_q[N-1:1]};
          carry_q <= co_d;
          cnt_q   <= cnt_q + 1'b1;
          // carry_q is the carry into the MSB on the last slice
          if (cnt_q == LAST) begin
            c_out_q <= co_d;
            ovf_q   <= co_d ^ carry_q;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = res_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed bench for the serial adder at N=8.
// Hand-computed vectors, immediate assertions, one summary line.
module tb_adder_serial_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         overflow;

  int vecs = 0;
  int errs = 0;

  adder_serial_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, N);
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta,
                        input logic [7:0] tb_, input logic ts,
                        input logic [7:0] es, input logic ec,
                        input logic eo, input int hold);
    a        = ta;
    b        = tb_;
    sub      = ts;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    wait_done(tag);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_c_out"}, c_out, ec);
    chk({tag, "_ovf"}, overflow, eo);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_sum"}, sum, es);
      chk({tag, "_hold_c_out"}, c_out, ec);
      chk({tag, "_hold_ovf"}, overflow, eo);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, out_valid, 0);
    chk({tag, "_rel_ready"}, in_ready, 1);
    chk({tag, "_rel_sum"}, sum, es);
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    sub       = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_ovf", overflow, 0);

    run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 2);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    run_op("sub_05_09", 8'h05, 8'h09, 1'b1, 8'hFC, 1'b0, 1'b0, 0);

    a = 8'hAA;
    b = 8'h55;
    repeat (3) step();
    chk("idle_sum", sum, 8'hFC);
    chk("idle_ready", in_ready, 1);

    // new request held high through RUN and DONE of the first one
    a        = 8'h3C;
    b        = 8'h05;
    sub      = 1'b0;
    in_valid = 1'b1;
    step();
    a   = 8'h7F;
    b   = 8'h01;
    sub = 1'b1;
    chk("busy_run_ready", in_ready, 0);
    wait_done("busy");
    chk("busy_sum", sum, 8'h41);
    chk("busy_c_out", c_out, 0);
    step();
    chk("busy_done_ready", in_ready, 0);
    chk("busy_done_sum", sum, 8'h41);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("busy_idle_ready", in_ready, 1);
    sub = 1'b0;
    step();
    in_valid = 1'b0;
    chk("second_run_ready", in_ready, 0);
    wait_done("second");
    chk("second_sum", sum, 8'h80);
    chk("second_ovf", overflow, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    a        = 8'h3C;
    b        = 8'h05;
    sub      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_c_out", c_out, 0);
    chk("mid_rst_ovf", overflow, 0);
    bad = 0;
    repeat (12) begin
      step();
      if (out_valid || !in_ready) bad++;
    end
    chk("mid_rst_no_result", bad, 0);

    run_op("stall_05_09", 8'h05, 8'h09, 1'b1, 8'hFC, 1'b0, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
